// File: rtl/wbq_pkg.sv
// Shared types and helpers for the writeback queue.
// Storage entries use the package default widths (WBQ_AW/WBQ_DW).
// youngest_index() maps an age rank to a circular storage slot.
package wbq_pkg;

  localparam int WBQ_AW = 5;
  localparam int WBQ_DW = 32;

  typedef struct packed {
    logic [WBQ_AW-1:0] addr;
    logic [WBQ_DW-1:0] data;
  } wb_entry_t;

  // Slot of the k-th youngest valid entry (k=0 is the tail-most entry).
  // The caller truncates to the pointer width; DEPTH is a power of two, so
  // truncation is the modulo wrap. Only meaningful for k < count.
  function automatic int unsigned youngest_index(input int unsigned rd_ptr,
                                                 input int unsigned count,
                                                 input int unsigned k);
    return rd_ptr + count - 1 - k;
  endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding lookup over the pending writeback entries for one read address.
// Latency: combinational. No handshake; purely observes queue state.
// Macro WBQ_BYPASS_EN: defined builds the comparators, undefined ties hit/data to 0.
// Ports: entries/rd_ptr/count (queue state), ra (lookup address),
//        hit (some pending entry targets ra, ra!=0), data (youngest match value).
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     rd_ptr,
  input  logic [CW-1:0]     count,
  input  logic [WBQ_AW-1:0] ra,
  output logic              hit,
  output logic [WBQ_DW-1:0] data
);

`ifdef WBQ_BYPASS_EN
  logic [PW-1:0] idx;

  // Walk from oldest to youngest so the youngest match is the last to land.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      idx = PW'(youngest_index(32'(rd_ptr), 32'(count), k));
      if ((k < int'(count)) && (ra != '0) && (entries[idx].addr == ra)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
`else
  // Read stage stalls on a non-empty queue instead of forwarding.
  assign hit  = 1'b0;
  assign data = '0;

  wb_entry_t         unused_entries [DEPTH];
  logic [PW-1:0]     unused_rd_ptr;
  logic [CW-1:0]     unused_count;
  logic [WBQ_AW-1:0] unused_ra;
  assign unused_entries = entries;
  assign unused_rd_ptr  = rd_ptr;
  assign unused_count   = count;
  assign unused_ra      = ra;
`endif

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers execute results in order and drains one per cycle into the regfile.
// Latency: entry accepted at edge N (empty queue, drain_en=1) is written at edge N+1.
// Backpressure: in_ready = !full (no pass-through when full); drain_en=0 holds the head.
// Optional forwarding built when WBQ_BYPASS_EN is defined (see wbq_fwd_match).
// Ports: clock/reset (async active-high); in_valid/in_ready/in_addr/in_data (enqueue);
//        drain_en, write/wa3/wd3 (regfile write port); ra1/ra2 -> hit1/hit2/fwd1/fwd2
//        (forwarding lookups); count (occupancy).
// AW/DW must equal the package widths WBQ_AW/WBQ_DW, which size the storage entries.
module wb_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic                       write,
  output logic [AW-1:0]              wa3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              ra1,
  input  logic [AW-1:0]              ra2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;
  wb_entry_t     head;

  // Gated by reset so nothing is accepted while the queue is being cleared.
  assign in_ready = !reset && (count_q != CW'(DEPTH));
  // Register 0 results complete the handshake but are never stored.
  assign enq      = in_valid && in_ready && (in_addr != '0);
  assign write    = (count_q != '0) && drain_en;
  assign deq      = write;

  assign head  = mem_q[rd_ptr_q];
  assign wa3   = (count_q != '0) ? head.addr : '0;
  assign wd3   = (count_q != '0) ? head.data : '0;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (enq && !deq)      count_d = count_q + CW'(1);
    else if (!enq && deq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: count_q qualifies every read of it.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= '{addr: in_addr, data: in_data};
  end

  wbq_fwd_match #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fwd1 (
    .entries (mem_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .ra      (ra1),
    .hit     (hit1),
    .data    (fwd1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fwd2 (
    .entries (mem_q),
    .rd_ptr  (rd_ptr_q),
    .count   (count_q),
    .ra      (ra2),
    .hit     (hit2),
    .data    (fwd2)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, single write, reg-0 drop, fill/backpressure,
// forwarding priority, mid-run reset and a wrapping stream.
module tb_wb_queue;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en, write;
  logic [4:0]  wa3, ra1, ra2;
  logic [31:0] wd3, fwd1, fwd2;
  logic        hit1, hit2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] rf [32];

  wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .write    (write),
    .wa3      (wa3),
    .wd3      (wd3),
    .ra1      (ra1),
    .ra2      (ra2),
    .hit1     (hit1),
    .hit2     (hit2),
    .fwd1     (fwd1),
    .fwd2     (fwd2),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural regfile fed by the queue's write port.
  always @(posedge clock) if (write) rf[wa3] <= wd3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b1; ra1 = '0; ra2 = '0;
    #2;
    chk("rst_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_write", write, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_hit1", hit1, 0);
    chk("rst_fwd2", fwd2, 0);
    #10 reset = 1'b0;
    tick();
    chk("idle_ready", in_ready, 1);
    chk("idle_count", count, 0);
    chk("idle_write", write, 0);

    // Single write
    push(5'd12, 32'd69);
    #1;
    chk("sw_write", write, 1);
    chk("sw_wa3", wa3, 12);
    chk("sw_wd3", wd3, 69);
    chk("sw_count", count, 1);
    tick();
    chk("sw_count0", count, 0);
    chk("sw_write0", write, 0);
    chk("sw_rf12", rf[12], 69);

    // Register-0 drop
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'd55;
    #1;
    chk("r0_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("r0_count", count, 0);
    chk("r0_write", write, 0);
    tick();
    chk("r0_write2", write, 0);

    // Fill and backpressure
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'(100 + i);
      #1;
      chk("fill_ready", in_ready, 1);
      tick();
    end
    in_addr = 5'd5; in_data = 32'd105;
    #1;
    chk("full_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("full_write", write, 0);
    tick();
    chk("held_count", count, 4);
    drain_en = 1'b1;
    #1;
    chk("dr_write", write, 1);
    chk("dr_wa3_1", wa3, 1);
    tick();
    chk("dr_ready", in_ready, 1);
    chk("dr_count3", count, 3);
    chk("dr_wa3_2", wa3, 2);
    tick();                     // 5th accepted while addr 2 drains
    in_valid = 1'b0;
    #1;
    chk("dr_count3b", count, 3);
    chk("dr_wa3_3", wa3, 3);
    tick();
    chk("dr_wa3_4", wa3, 4);
    tick();
    chk("dr_wa3_5", wa3, 5);
    chk("dr_wd3_5", wd3, 105);
    tick();
    chk("dr_empty", count, 0);
    chk("dr_rf4", rf[4], 104);

    // Forwarding priority
    drain_en = 1'b0;
    push(5'd7, 32'd10);
    push(5'd7, 32'd20);
    push(5'd0, 32'd99);
    push(5'd9, 32'd30);
    ra1 = 5'd7; ra2 = 5'd0;
    #1;
    chk("fw_count", count, 3);
    chk("fw_hit1", hit1, BYP ? 1 : 0);
    chk("fw_fwd1", fwd1, BYP ? 20 : 0);
    chk("fw_hit2_r0", hit2, 0);
    chk("fw_fwd2_r0", fwd2, 0);
    ra2 = 5'd9;
    #1;
    chk("fw_hit2", hit2, BYP ? 1 : 0);
    chk("fw_fwd2", fwd2, BYP ? 30 : 0);
    ra2 = 5'd3;
    #1;
    chk("fw_miss", hit2, 0);
    drain_en = 1'b1;
    tick();                     // retire older addr-7 entry
    drain_en = 1'b0;
    #1;
    chk("fw_after_hit1", hit1, BYP ? 1 : 0);
    chk("fw_after_fwd1", fwd1, BYP ? 20 : 0);
    drain_en = 1'b1;
    tick();
    tick();
    ra1 = '0; ra2 = '0;
    #1;
    chk("fw_empty", count, 0);
    chk("fw_rf7", rf[7], 20);

    // Reset mid-run
    drain_en = 1'b0;
    push(5'd1, 32'd1);
    push(5'd2, 32'd2);
    push(5'd3, 32'd3);
    chk("mr_count3", count, 3);
    drain_en = 1'b1;
    #1;
    chk("mr_write1", write, 1);
    reset = 1'b1;
    #1;
    chk("mr_count0", count, 0);
    chk("mr_write0", write, 0);
    chk("mr_ready0", in_ready, 0);
    chk("mr_wa3", wa3, 0);
    reset = 1'b0;
    tick();
    chk("mr_ready1", in_ready, 1);
    chk("mr_count_post", count, 0);

    // Wrap with simultaneous enqueue/dequeue
    drain_en = 1'b1;
    ra2 = 5'd31;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_addr = 5'(11 + i); in_data = 32'(200 + i);
      tick();
      ra1 = 5'(11 + i);
      #1;
      chk("st_count", count, 1);
      chk("st_write", write, 1);
      chk("st_wa3", wa3, 32'(11 + i));
      chk("st_wd3", wd3, 32'(200 + i));
      chk("st_hit1", hit1, BYP ? 1 : 0);
      chk("st_fwd1", fwd1, BYP ? 32'(200 + i) : 0);
      chk("st_hit2", hit2, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("st_empty", count, 0);
    chk("st_rf20", rf[20], 209);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
